// File: rtl/vram_arb_pkg.sv
// Shared types and default geometry for the video/data RAM arbiter.
// The VGA fetcher and the memory wrapper use the same geometry.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W     = 16;
  localparam int VRAM_DATA_W     = 32;
  localparam int VRAM_STARVE_LIM = 4;

  // Owner of the read whose data returns in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  // Counter width that holds 0..lim. A limit below 1 is clamped to a 1-bit counter.
  function automatic int cnt_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which the CPU lost arbitration.
// sat tells the grant logic to force a CPU grant.
module vram_arb_starve_ctr
  import vram_arb_pkg::*;
#(
  parameter int LIM = VRAM_STARVE_LIM
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_width(LIM);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(LIM));

  // A clear wins over an increment. This covers a CPU grant in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video/data RAM between the CPU load/store unit and the
// VGA pixel fetcher. VGA wins by default. The CPU is forced in after STARVE_LIM losses.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int STARVE_LIM = VRAM_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a request stays asserted with stable fields until its gnt.
  // The gnt cycle consumes the request. Dropping a request without a gnt is legal.
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              starve_sat;
  logic              starve_inc;
  logic              starve_clr;
  owner_t            rd_owner;
  owner_t            rd_owner_nxt;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] vga_hold;

  // Grants are combinational from the requests and registered state, and are held off in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && (!vga_req || starve_sat)) begin
        cpu_gnt = 1'b1;
      end else if (vga_req) begin
        vga_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign starve_inc = cpu_req & vga_req & ~cpu_gnt;
  assign starve_clr = ~cpu_req | cpu_gnt;

  vram_arb_starve_ctr #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  assign mem_en    = cpu_gnt | vga_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : vga_addr;
  assign mem_wdata = cpu_wdata;

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_nxt = OWN_CPU;
    end else if (vga_gnt) begin
      rd_owner_nxt = OWN_VGA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
    end
  end

  // Gating rvalid with rst drops a read that is still in flight when reset arrives.
  assign cpu_rvalid = ~rst & (rd_owner == OWN_CPU);
  assign vga_rvalid = ~rst & (rd_owner == OWN_VGA);

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold <= '0;
      vga_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold <= mem_rdata;
      if (vga_rvalid) vga_hold <= mem_rdata;
    end
  end

  // Each requester sees RAM data only in its own rvalid cycle. At other times it keeps its last word.
  assign cpu_rdata = rst ? '0 : (cpu_rvalid ? mem_rdata : cpu_hold);
  assign vga_rdata = rst ? '0 : (vga_rvalid ? mem_rdata : vga_hold);

endmodule
